// File: rtl/vespa_timer_pkg.sv
// Shared constants and types for the VeSPA down-counting timer.
// Word-index register map (byte address bits [4:2]), CTRL layout and FSM encoding.
package vespa_timer_pkg;

  localparam logic [2:0] TMR_CTRL   = 3'd0;
  localparam logic [2:0] TMR_LOAD   = 3'd1;
  localparam logic [2:0] TMR_COUNT  = 3'd2;
  localparam logic [2:0] TMR_CMP    = 3'd3;
  localparam logic [2:0] TMR_STATUS = 3'd4;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN      = 2;
  localparam int CTRL_PWM_EN      = 3;
  localparam int CTRL_PRE_LSB     = 8;
  localparam int CTRL_PRE_MSB     = 15;

  localparam int STAT_EXPIRED = 0;
  localparam int STAT_RUNNING = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tmr_state_e;

  // EN lives in the FSM state, so the stored CTRL fields exclude it.
  typedef struct packed {
    logic [7:0] prescale;
    logic       pwm_en;
    logic       irq_en;
    logic       auto_reload;
  } tmr_ctrl_t;

endpackage

// File: rtl/vespa_timer_prescaler.sv
// 8-bit prescaler: emits a one-cycle tick every PRESCALE+1 cycles while running.
module vespa_timer_prescaler (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       run_i,
  input  logic [7:0] prescale_i,
  output logic       tick_o
);

  logic [7:0] pre_q, pre_d;

  assign tick_o = run_i && (pre_q == prescale_i);

  always_comb begin
    pre_d = pre_q + 8'd1;
    if (clear_i || !run_i || tick_o) pre_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pre_q <= '0;
    else       pre_q <= pre_d;
  end

endmodule

// File: rtl/vespa_timer.sv
// Memory-mapped down-counting timer with prescaler, expiry IRQ and optional PWM.
// Optional PWM (CMP register, CTRL.PWM_EN, o_Pwm) is built only with VESPA_TIMER_PWM_EN.
module vespa_timer
  import vespa_timer_pkg::*;
#(
  parameter logic [31:0] RESET_LOAD = 32'hFFFF_FFFF
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_WEnable,
  input  logic [31:0] i_WAddr,
  input  logic [31:0] i_WData,
  input  logic        i_REnable,
  input  logic [31:0] i_RAddr,
  output logic [31:0] o_RData,
  output logic        o_Irq,
  output logic        o_Pwm
);

  tmr_state_e  state_q, state_d;
  tmr_ctrl_t   ctrl_q, ctrl_d;
  logic [31:0] load_q, load_d, count_q, count_d, cmp_rd;
  logic        expired_q, expired_d;
  logic        run, start, tick, expire;
  logic [2:0]  waddr;
  logic        we_ctrl, we_load, we_count, we_status;
  logic        unused_inputs;

  assign unused_inputs = ^{i_WAddr[31:5], i_WAddr[1:0], i_RAddr[31:5], i_RAddr[1:0], i_REnable};

  assign waddr     = i_WAddr[4:2];
  assign we_ctrl   = i_WEnable && (waddr == TMR_CTRL);
  assign we_load   = i_WEnable && (waddr == TMR_LOAD);
  assign we_count  = i_WEnable && (waddr == TMR_COUNT);
  assign we_status = i_WEnable && (waddr == TMR_STATUS);

  vespa_timer_prescaler u_pre (
    .clk_i      (i_Clk),
    .rst_i      (i_Reset),
    .clear_i    (start),
    .run_i      (run),
    .prescale_i (ctrl_q.prescale),
    .tick_o     (tick)
  );

  // A COUNT write in a tick cycle swallows that tick, expiry included.
  assign expire = tick && (count_q == '0) && !we_count;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (we_ctrl && i_WData[CTRL_EN]) state_d = ST_RUN;
      ST_RUN:  if ((we_ctrl && !i_WData[CTRL_EN]) || (expire && !ctrl_q.auto_reload))
                 state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    run   = (state_q == ST_RUN);
    start = (state_q == ST_IDLE) && we_ctrl && i_WData[CTRL_EN];
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (we_ctrl) begin
      ctrl_d.prescale    = i_WData[CTRL_PRE_MSB:CTRL_PRE_LSB];
      ctrl_d.irq_en      = i_WData[CTRL_IRQ_EN];
      ctrl_d.auto_reload = i_WData[CTRL_AUTO_RELOAD];
`ifdef VESPA_TIMER_PWM_EN
      ctrl_d.pwm_en      = i_WData[CTRL_PWM_EN];
`else
      ctrl_d.pwm_en      = 1'b0;
`endif
    end
    load_d = we_load ? i_WData : load_q;
    count_d = count_q;
    if (we_count)   count_d = i_WData;
    else if (start) count_d = load_q;
    else if (tick)  count_d = (count_q != '0) ? count_q - 32'd1
                            : (ctrl_q.auto_reload ? load_q : '0);
    expired_d = expire || (expired_q && !(we_status && i_WData[STAT_EXPIRED]));
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      ctrl_q    <= '0;
      load_q    <= RESET_LOAD;
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

`ifdef VESPA_TIMER_PWM_EN
  logic [31:0] cmp_q, cmp_d;
  logic        pwm_q, pwm_d;
  logic        we_cmp;

  assign we_cmp = i_WEnable && (waddr == TMR_CMP);
  assign cmp_d  = we_cmp ? i_WData : cmp_q;
  assign pwm_d  = run && ctrl_q.pwm_en && (count_q < cmp_q);

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      cmp_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cmp_q <= cmp_d;
      pwm_q <= pwm_d;
    end
  end

  assign cmp_rd = cmp_q;
  assign o_Pwm  = pwm_q;
`else
  assign cmp_rd = '0;
  assign o_Pwm  = 1'b0;
`endif

  assign o_Irq = expired_q && ctrl_q.irq_en;

  always_comb begin
    o_RData = '0;
    case (i_RAddr[4:2])
      TMR_CTRL: begin
        o_RData[CTRL_EN]                   = run;
        o_RData[CTRL_AUTO_RELOAD]          = ctrl_q.auto_reload;
        o_RData[CTRL_IRQ_EN]               = ctrl_q.irq_en;
        o_RData[CTRL_PWM_EN]               = ctrl_q.pwm_en;
        o_RData[CTRL_PRE_MSB:CTRL_PRE_LSB] = ctrl_q.prescale;
      end
      TMR_LOAD:  o_RData = load_q;
      TMR_COUNT: o_RData = count_q;
      TMR_CMP:   o_RData = cmp_rd;
      TMR_STATUS: begin
        o_RData[STAT_EXPIRED] = expired_q;
        o_RData[STAT_RUNNING] = run;
      end
      default:   o_RData = '0;
    endcase
  end

endmodule
